// File: rtl/id_issue_queue.sv
// id_issue_queue: in-order decode-to-issue buffer.
// Accepts up to NR_IN decoded entries per cycle and presents the oldest NR_OUT
// entries to issue, which retires an in-order prefix of them each cycle.
// Space freed by a same-cycle ack is immediately reusable by the decoders.
module id_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int NR_IN  = 2,
  parameter int NR_OUT = 2,
  parameter int WIDTH  = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic [NR_IN-1:0]              fetch_valid_i,
  input  logic [NR_IN-1:0][WIDTH-1:0]   fetch_data_i,
  output logic [NR_IN-1:0]              fetch_ready_o,
  output logic [NR_OUT-1:0]             issue_valid_o,
  output logic [NR_OUT-1:0][WIDTH-1:0]  issue_data_o,
  input  logic [NR_OUT-1:0]             issue_ack_i,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int FW = CW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q;
  logic [PW-1:0]    wr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    deq;
  logic [CW-1:0]    enq;
  logic [FW-1:0]    free;

  assign count_o = count_q;

  // Issue lanes: lane j shows the j-th oldest entry, zero when not valid
  always_comb begin
    issue_valid_o = '0;
    issue_data_o  = '0;
    for (int j = 0; j < NR_OUT; j++) begin
      if (CW'(j) < count_q) begin
        issue_valid_o[j] = 1'b1;
        issue_data_o[j]  = mem_q[rd_q + PW'(j)];
      end
    end
  end

  // Dequeue count: acked lanes among the valid ones
  always_comb begin
    deq = '0;
    for (int j = 0; j < NR_OUT; j++) begin
      deq = deq + CW'(issue_ack_i[j] & issue_valid_o[j]);
    end
  end

  // Ready prefix from free space (acked slots count as free); enqueue count
  always_comb begin
    free          = FW'(DEPTH) - {1'b0, count_q} + {1'b0, deq};
    fetch_ready_o = '0;
    enq           = '0;
    for (int i = 0; i < NR_IN; i++) begin
      fetch_ready_o[i] = !flush_i && (FW'(i) < free);
      enq              = enq + CW'(fetch_valid_i[i] & fetch_ready_o[i]);
    end
  end

  // Pointers and occupancy; flush drops everything and ignores acks
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_q + PW'(deq);
      wr_q    <= wr_q + PW'(enq);
      count_q <= count_q + enq - deq;
    end
  end

  // Payload storage; accepted lanes land at consecutive slots after wr_q
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      for (int i = 0; i < NR_IN; i++) begin
        if (fetch_valid_i[i] && fetch_ready_o[i]) begin
          mem_q[wr_q + PW'(i)] <= fetch_data_i[i];
        end
      end
    end
  end

`ifndef SYNTHESIS
  // A stalled decode entry must reappear, unchanged, shifted down by the
  // number of lanes accepted alongside it.
  logic [NR_IN-1:0]            stall_q;
  logic [NR_IN-1:0][WIDTH-1:0] data_q;
  logic [CW-1:0]               enq_q;

  // Remember last cycle's stalled lanes for the stability check
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
      data_q  <= '0;
      enq_q   <= '0;
    end else begin
      stall_q <= flush_i ? '0 : (fetch_valid_i & ~fetch_ready_o);
      data_q  <= fetch_data_i;
      enq_q   <= enq;
    end
  end

  // Handshake protocol checks
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert ((fetch_valid_i & (fetch_valid_i + NR_IN'(1))) == '0);
      assert ((issue_ack_i & (issue_ack_i + NR_OUT'(1))) == '0);
      assert ((issue_ack_i & ~issue_valid_o) == '0);
      if (!flush_i) begin
        for (int i = 0; i < NR_IN; i++) begin
          for (int j = 0; j < NR_IN; j++) begin
            if (stall_q[i] && (int'(enq_q) + j == i)) begin
              assert (fetch_valid_i[j] && (fetch_data_i[j] == data_q[i]));
            end
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed and scoreboard-checked bench for id_issue_queue (DEPTH=4, 2 in, 2 out).
module tb_id_issue_queue;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic [1:0]       fetch_valid_i;
  logic [1:0][63:0] fetch_data_i;
  logic [1:0]       fetch_ready_o;
  logic [1:0]       issue_valid_o;
  logic [1:0][63:0] issue_data_o;
  logic [1:0]       issue_ack_i;
  logic [2:0]       count_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] q[$];
  int next_in, pend, nv, na, cnt, fr, er, ne, cycles, nvis;

  always #5 clk_i = ~clk_i;

  id_issue_queue #(.DEPTH(4), .NR_IN(2), .NR_OUT(2), .WIDTH(64)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_data_i  (fetch_data_i),
    .fetch_ready_o (fetch_ready_o),
    .issue_valid_o (issue_valid_o),
    .issue_data_o  (issue_data_o),
    .issue_ack_i   (issue_ack_i),
    .count_o       (count_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] ack, input logic fl);
    fetch_valid_i   = v;
    fetch_data_i[0] = d0;
    fetch_data_i[1] = d1;
    issue_ack_i     = ack;
    flush_i         = fl;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [1:0] pmask(input int n);
    return (n >= 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
  endfunction

  initial begin
    // Reset / idle
    rst_ni = 1'b0;
    drive(2'b11, 64'hA0, 64'hB0, 2'b00, 1'b0);
    #2;
    check_eq("rst_count", count_o, 0);
    check_eq("rst_valid", issue_valid_o, 2'b00);
    check_eq("rst_ready", fetch_ready_o, 2'b11);
    check_eq("rst_data0", issue_data_o[0], 0);
    repeat (2) cyc();
    check_eq("rst_count_hold", count_o, 0);
    rst_ni = 1'b1;
    #1;
    check_eq("rel_ready", fetch_ready_o, 2'b11);
    cyc();
    check_eq("first_count", count_o, 2);
    check_eq("first_valid", issue_valid_o, 2'b11);
    check_eq("first_data0", issue_data_o[0], 64'hA0);
    check_eq("first_data1", issue_data_o[1], 64'hB0);
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    cyc();
    check_eq("drain_count", count_o, 0);

    // Fill to full (pointers start at 2, so this wraps)
    drive(2'b11, 1, 2, 2'b00, 1'b0);
    #1;
    check_eq("fill1_ready", fetch_ready_o, 2'b11);
    cyc();
    check_eq("fill1_count", count_o, 2);
    drive(2'b11, 3, 4, 2'b00, 1'b0);
    #1;
    check_eq("fill2_ready", fetch_ready_o, 2'b11);
    cyc();
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    #1;
    check_eq("full_count", count_o, 4);
    check_eq("full_ready", fetch_ready_o, 2'b00);
    check_eq("full_data0", issue_data_o[0], 1);
    check_eq("full_data1", issue_data_o[1], 2);
    drive(2'b01, 5, 0, 2'b01, 1'b0);
    #1;
    check_eq("full_ack1_ready", fetch_ready_o, 2'b01);
    cyc();
    check_eq("full_ack1_count", count_o, 4);
    check_eq("full_ack1_data0", issue_data_o[0], 2);
    check_eq("full_ack1_data1", issue_data_o[1], 3);
    drive(2'b00, 0, 0, 2'b11, 1'b0);
    #1;
    check_eq("full_ack2_ready", fetch_ready_o, 2'b11);
    cyc();
    check_eq("ack2_count", count_o, 2);
    check_eq("ack2_data0", issue_data_o[0], 4);
    check_eq("ack2_data1", issue_data_o[1], 5);

    // Flush with 3 entries held
    drive(2'b01, 6, 0, 2'b00, 1'b0);
    cyc();
    check_eq("pre_flush_count", count_o, 3);
    drive(2'b11, 7, 8, 2'b01, 1'b1);
    #1;
    check_eq("flush_ready", fetch_ready_o, 2'b00);
    cyc();
    drive(2'b01, 64'h77, 0, 2'b00, 1'b0);
    #1;
    check_eq("flush_count", count_o, 0);
    check_eq("flush_valid", issue_valid_o, 2'b00);
    cyc();
    check_eq("post_flush_valid", issue_valid_o, 2'b01);
    check_eq("post_flush_data0", issue_data_o[0], 64'h77);
    check_eq("post_flush_count", count_o, 1);
    drive(2'b00, 0, 0, 2'b00, 1'b1);
    cyc();

    // Full-rate steady state
    next_in = 100;
    cnt     = 0;
    for (int c = 0; c < 8; c++) begin
      drive(2'b11, 64'(next_in), 64'(next_in + 1), (cnt >= 2) ? 2'b11 : 2'b00, 1'b0);
      #1;
      if (c > 0) begin
        check_eq("ss_ready", fetch_ready_o, 2'b11);
        check_eq("ss_data0", issue_data_o[0], 64'(next_in - 2));
        check_eq("ss_data1", issue_data_o[1], 64'(next_in - 1));
      end
      cyc();
      next_in += 2;
      cnt = 2;
      check_eq("ss_count", count_o, 2);
    end
    drive(2'b00, 0, 0, 2'b00, 1'b1);
    cyc();

    // Random prefix stream against a scoreboard queue
    q.delete();
    next_in = 0;
    pend    = 0;
    cycles  = 0;
    while ((next_in < 1000 || q.size() > 0) && cycles < 6000) begin
      cnt = q.size();
      nv  = $urandom_range(2, 0);
      if (nv < pend) nv = pend;
      if (nv > 1000 - next_in) nv = 1000 - next_in;
      na  = $urandom_range(2, 0);
      if (na > cnt) na = cnt;
      drive(pmask(nv), 64'(next_in), 64'(next_in + 1), pmask(na), 1'b0);
      #1;
      fr   = 4 - cnt + na;
      er   = (fr > 2) ? 2 : fr;
      nvis = (cnt > 2) ? 2 : cnt;
      check_eq("st_ready", fetch_ready_o, pmask(er));
      check_eq("st_valid", issue_valid_o, pmask(nvis));
      if (nvis > 0) check_eq("st_data0", issue_data_o[0], q[0]);
      if (nvis > 1) check_eq("st_data1", issue_data_o[1], q[1]);
      ne = (nv < er) ? nv : er;
      cyc();
      for (int k = 0; k < na; k++) void'(q.pop_front());
      for (int k = 0; k < ne; k++) q.push_back(64'(next_in + k));
      next_in += ne;
      pend = nv - ne;
      cycles++;
      check_eq("st_count", count_o, 64'(q.size()));
    end
    check_eq("st_all_in", next_in, 1000);
    check_eq("st_all_out", q.size(), 0);
    drive(2'b00, 0, 0, 2'b00, 1'b0);

    // Async reset mid-stream
    drive(2'b11, 64'h11, 64'h12, 2'b00, 1'b0);
    cyc();
    drive(2'b01, 64'h13, 0, 2'b00, 1'b0);
    cyc();
    check_eq("ar_pre_count", count_o, 3);
    drive(2'b00, 0, 0, 2'b00, 1'b0);
    #3;
    rst_ni = 1'b0;
    #1;
    check_eq("ar_count", count_o, 0);
    check_eq("ar_valid", issue_valid_o, 2'b00);
    cyc();
    rst_ni = 1'b1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
